fork_data: RTL and testbench
============================

FORK_DATA -- requirements
Module: fork_data

Interface
REQ-001: Parameter SIZE, default 2, SHALL set the number of output channels (legal range 1..32).
REQ-002: Parameter DATA_TYPE, default 32, SHALL set the data width in bits.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst  input  1  SHALL be the reset, asynchronous and active-low (0 = reset asserted).
REQ-005: ins  input  DATA_TYPE  SHALL carry the input token data.
REQ-006: ins_valid  input  1  SHALL flag a valid input token.
REQ-007: ins_ready  output  1  SHALL indicate the input token is consumed this cycle.
REQ-008: outs  output  SIZE*DATA_TYPE  SHALL carry the data for output channel i in bits [i*DATA_TYPE +: DATA_TYPE].
REQ-009: outs_valid  output  SIZE  SHALL flag a valid token per output channel.
REQ-010: outs_ready  input  SIZE  SHALL be the per-channel consumer ready.
REQ-011: token_count  output  32  SHALL count completed input handshakes.

Function
REQ-012: The block SHALL be an eager fork: each input token is delivered exactly once to every output channel; channels accept independently.
REQ-013: Per channel i, a pending flag pend[i] SHALL record that the current token is not yet delivered on channel i.
REQ-014: outs[i] SHALL equal ins combinationally on every channel; there is no data register and the data latency is 0 cycles.
REQ-015: outs_valid[i] SHALL equal ins_valid AND pend[i].
REQ-016: stall[i] SHALL equal outs_valid[i] AND NOT outs_ready[i], and any_stall SHALL equal the OR of stall[i] over all channels.
REQ-017: ins_ready SHALL equal NOT any_stall, combinationally.
REQ-018: Per-channel state machine, two states:
- PEND (pend=1): moves to DONE when ins_valid=1, outs_ready[i]=1 and any_stall=1.
- DONE (pend=0): moves to PEND when any_stall=0 or ins_valid=0.
REQ-019: When ins_valid=1 and any_stall=0, the input handshake SHALL complete that cycle and all pend flags SHALL return to 1.
REQ-020: A channel in DONE SHALL hold outs_valid[i]=0 and SHALL NOT deliver the same token twice, regardless of outs_ready[i].
REQ-021: If all still-pending channels become ready in the same cycle, the handshake SHALL complete that cycle with no extra bubble.
REQ-022: The protocol requires ins_valid and ins to stay stable until ins_ready; if ins_valid drops anyway, all pend flags SHALL return to 1 on the next edge.
REQ-023: Only combinational paths ins_valid/outs_ready -> outs_valid/ins_ready and ins -> outs SHALL exist; no path SHALL run from outs_ready[i] to outs_valid[i] of the same channel.
REQ-024: token_count SHALL increment by 1 on each cycle with ins_valid=1 and ins_ready=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-025: With SIZE=1, the block SHALL behave as a wire: ins_ready = outs_ready[0], with no state effect.

Reset
REQ-026: While rst=0, all pend flags SHALL be 1 and token_count SHALL be 0, asynchronously and regardless of clk.
REQ-027: During reset, the outputs SHALL read outs_valid = {SIZE{ins_valid}}, ins_ready = 1 when no stall exists, and token_count = 0.
REQ-028: Reset asserted mid-token SHALL discard partial-delivery state, and the token SHALL be re-offered to all channels after release.
REQ-029: Reset release SHALL be synchronized by the integrator; the block adds no synchronizer.

Verification
REQ-030: SIZE=2, DATA_TYPE=32, ins=0x3F800000, ins_valid=1, outs_ready=2'b11 -> outs_valid=2'b11, ins_ready=1, both outs=0x3F800000, token_count 0->1.
REQ-031: outs_ready=2'b01 for 3 cycles, then 2'b10 -> cycle 0: outs_valid=2'b11, ins_ready=0; cycles 1-2: outs_valid=2'b10; cycle 3: ins_ready=1, token_count +1; channel 0 receives exactly 1 token.
REQ-032: SIZE=3, ready patterns 3'b001, 3'b100, 3'b010 on consecutive cycles -> exactly one transfer per channel, ins_ready=1 only on cycle 3, and pend back to 3'b111 after.
REQ-033: Channel 1 mid-stall (pend=2'b10), rst pulsed low between clock edges -> pend=2'b11 immediately, token_count=0, and outs_valid=2'b11 after release.
REQ-034: Preload token_count=0xFFFFFFFF via force, then one handshake -> token_count=0.
REQ-035: Random outs_ready on 10,000 tokens, SIZE=4 -> each channel's scoreboard matches the input sequence exactly, with no drops or duplicates.

Source files
------------

// File: rtl/fork_data.sv
`default_nettype none
// ============================================================================
// Module   : fork_data
// Purpose  : Eager fork; broadcasts each input token once to every output
//            channel, with independent per-channel acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module fork_data #(
    parameter int SIZE      = 2,
    parameter int DATA_TYPE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_TYPE-1:0]      ins,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    output logic [SIZE*DATA_TYPE-1:0] outs,
    output logic [SIZE-1:0]           outs_valid,
    input  logic [SIZE-1:0]           outs_ready,
    output logic [31:0]               token_count
);

    typedef enum logic [0:0] {
        ST_DONE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    logic [SIZE-1:0] w_pend;
    logic            w_xfer;
    logic [31:0]     r_token_count;

    // Data is never stored: every channel sees the live input bus.
    assign outs = {SIZE{ins}};

    generate
        if (SIZE == 1) begin : g_single
            assign w_pend     = 1'b1;
            assign outs_valid = ins_valid & w_pend;
            assign ins_ready  = outs_ready[0];
        end else begin : g_multi
            logic [SIZE-1:0] w_stall;
            logic            w_any_stall;

            // Valid depends only on registered pend, never on this channel's ready.
            assign outs_valid  = {SIZE{ins_valid}} & w_pend;
            assign w_stall     = outs_valid & ~outs_ready;
            assign w_any_stall = |w_stall;
            assign ins_ready   = ~w_any_stall;

            for (genvar i = 0; i < SIZE; i++) begin : g_chan
                state_t r_state;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_state <= ST_PEND;
                    end else begin
                        case (r_state)
                            ST_PEND: if (ins_valid && outs_ready[i] && w_any_stall)
                                         r_state <= ST_DONE;
                            ST_DONE: if (!w_any_stall || !ins_valid)
                                         r_state <= ST_PEND;
                        endcase
                    end
                end

                assign w_pend[i] = (r_state == ST_PEND);
            end
        end
    endgenerate

    assign w_xfer = ins_valid & ins_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_token_count <= 32'd0;
        end else if (w_xfer) begin
            r_token_count <= r_token_count + 32'd1;
        end
    end

    assign token_count = r_token_count;

endmodule
`default_nettype wire

// File: tb/tb_fork_data.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fork_data
// Purpose  : Self-checking bench for fork_data (SIZE 2, 3 and 4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fork_data;

    localparam int NTOK = 10000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // SIZE=2 instance
    logic [31:0] ins2 = '0;
    logic        iv2  = 1'b0;
    logic        ir2;
    logic [63:0] outs2;
    logic [1:0]  ov2;
    logic [1:0]  or2  = '0;
    logic [31:0] tc2;

    // SIZE=3 instance
    logic [31:0] ins3 = '0;
    logic        iv3  = 1'b0;
    logic        ir3;
    logic [95:0] outs3;
    logic [2:0]  ov3;
    logic [2:0]  or3  = '0;
    logic [31:0] tc3;

    // SIZE=4 instance
    logic [31:0]  ins4 = '0;
    logic         iv4  = 1'b0;
    logic         ir4;
    logic [127:0] outs4;
    logic [3:0]   ov4;
    logic [3:0]   or4  = '0;
    logic [31:0]  tc4;

    fork_data #(.SIZE(2), .DATA_TYPE(32)) u_dut2 (
        .clk(clk), .rst(rst), .ins(ins2), .ins_valid(iv2), .ins_ready(ir2),
        .outs(outs2), .outs_valid(ov2), .outs_ready(or2), .token_count(tc2)
    );

    fork_data #(.SIZE(3), .DATA_TYPE(32)) u_dut3 (
        .clk(clk), .rst(rst), .ins(ins3), .ins_valid(iv3), .ins_ready(ir3),
        .outs(outs3), .outs_valid(ov3), .outs_ready(or3), .token_count(tc3)
    );

    fork_data #(.SIZE(4), .DATA_TYPE(32)) u_dut4 (
        .clk(clk), .rst(rst), .ins(ins4), .ins_valid(iv4), .ins_ready(ir4),
        .outs(outs4), .outs_valid(ov4), .outs_ready(or4), .token_count(tc4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Delivery counters for the directed instances
    int deliv2 [2];
    int deliv3 [3];
    initial begin
        foreach (deliv2[i]) deliv2[i] = 0;
        foreach (deliv3[i]) deliv3[i] = 0;
    end
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) if (ov2[i] && or2[i]) deliv2[i]++;
        for (int i = 0; i < 3; i++) if (ov3[i] && or3[i]) deliv3[i]++;
    end

    // Scoreboard for the SIZE=4 instance
    logic [31:0] sb [4][$];
    logic [31:0] exp_tc4 = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ov4[i] && or4[i]) begin
                chk($sformatf("ch%0d_has_expected", i), 64'(sb[i].size() != 0), 64'd1);
                if (sb[i].size() != 0)
                    chk($sformatf("ch%0d_data", i), 64'(outs4[i*32 +: 32]), 64'(sb[i].pop_front()));
            end
        end
        if (iv4 && ir4) begin
            chk("tc4_count", 64'(tc4), 64'(exp_tc4));
            exp_tc4 = exp_tc4 + 32'd1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  d0, d1, cyc;
        logic done;

        // Reset state with a token offered while in reset
        tick();
        iv2 = 1'b1;
        or2 = 2'b00;
        mid();
        chk("rst_tc2", 64'(tc2), 64'd0);
        chk("rst_ov2", 64'(ov2), 64'h3);
        chk("rst_pend2", 64'(u_dut2.w_pend), 64'h3);
        chk("rst_ir2_stall", 64'(ir2), 64'd0);
        tick();
        iv2 = 1'b0;
        mid();
        chk("rst_ir2_idle", 64'(ir2), 64'd1);
        rst = 1'b1;
        tick();

        // Full broadcast in one cycle
        ins2 = 32'h3F80_0000;
        iv2  = 1'b1;
        or2  = 2'b11;
        mid();
        chk("bc_ov2", 64'(ov2), 64'h3);
        chk("bc_ir2", 64'(ir2), 64'd1);
        chk("bc_outs2", 64'(outs2), 64'h3F80_0000_3F80_0000);
        chk("bc_tc2_before", 64'(tc2), 64'd0);
        tick();
        iv2 = 1'b0;
        chk("bc_tc2_after", 64'(tc2), 64'd1);

        // Channel 0 ready early, channel 1 ready only on the 4th cycle
        d0   = deliv2[0];
        d1   = deliv2[1];
        ins2 = 32'hA5A5_0001;
        iv2  = 1'b1;
        or2  = 2'b01;
        mid();
        chk("st_c0_ov2", 64'(ov2), 64'h3);
        chk("st_c0_ir2", 64'(ir2), 64'd0);
        tick();
        mid();
        chk("st_c1_ov2", 64'(ov2), 64'h2);
        chk("st_c1_ir2", 64'(ir2), 64'd0);
        tick();
        mid();
        chk("st_c2_ov2", 64'(ov2), 64'h2);
        tick();
        or2 = 2'b10;
        mid();
        chk("st_c3_ir2", 64'(ir2), 64'd1);
        chk("st_c3_ch1_data", 64'(outs2[63:32]), 64'hA5A5_0001);
        tick();
        iv2 = 1'b0;
        chk("st_tc2", 64'(tc2), 64'd2);
        chk("st_deliv_ch0", 64'(deliv2[0] - d0), 64'd1);
        chk("st_deliv_ch1", 64'(deliv2[1] - d1), 64'd1);
        chk("st_pend2_after", 64'(u_dut2.w_pend), 64'h3);

        // Asynchronous reset mid-token
        ins2 = 32'h1234_5678;
        iv2  = 1'b1;
        or2  = 2'b01;
        mid();
        chk("ar_ir2", 64'(ir2), 64'd0);
        tick();
        or2 = 2'b00;
        mid();
        chk("ar_pend_partial", 64'(u_dut2.w_pend), 64'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_pend_reset", 64'(u_dut2.w_pend), 64'h3);
        chk("ar_tc2_reset", 64'(tc2), 64'd0);
        #1;
        rst = 1'b1;
        tick();
        or2 = 2'b11;
        mid();
        chk("ar_ov2_reoffer", 64'(ov2), 64'h3);
        chk("ar_ir2_reoffer", 64'(ir2), 64'd1);
        tick();
        iv2 = 1'b0;
        chk("ar_tc2_after", 64'(tc2), 64'd1);

        // Counter wrap
        force u_dut2.r_token_count = 32'hFFFF_FFFF;
        #1;
        release u_dut2.r_token_count;
        ins2 = 32'hDEAD_BEEF;
        iv2  = 1'b1;
        or2  = 2'b11;
        mid();
        chk("wr_tc2_pre", 64'(tc2), 64'hFFFF_FFFF);
        chk("wr_ir2", 64'(ir2), 64'd1);
        tick();
        iv2 = 1'b0;
        chk("wr_tc2_post", 64'(tc2), 64'd0);

        // SIZE=3 staggered readiness
        ins3 = 32'h0BAD_F00D;
        iv3  = 1'b1;
        or3  = 3'b001;
        mid();
        chk("s3_c0_ov3", 64'(ov3), 64'h7);
        chk("s3_c0_ir3", 64'(ir3), 64'd0);
        tick();
        or3 = 3'b100;
        mid();
        chk("s3_c1_ov3", 64'(ov3), 64'h6);
        chk("s3_c1_ir3", 64'(ir3), 64'd0);
        tick();
        or3 = 3'b010;
        mid();
        chk("s3_c2_ov3", 64'(ov3), 64'h2);
        chk("s3_c2_ir3", 64'(ir3), 64'd1);
        tick();
        iv3 = 1'b0;
        or3 = 3'b000;
        chk("s3_pend_after", 64'(u_dut3.w_pend), 64'h7);
        chk("s3_tc3", 64'(tc3), 64'd1);
        for (int i = 0; i < 3; i++)
            chk($sformatf("s3_deliv_ch%0d", i), 64'(deliv3[i]), 64'd1);

        // SIZE=4 random back-pressure, scoreboard checked by the monitor
        for (int t = 0; t < NTOK; t++) begin
            ins4 = $urandom;
            iv4  = 1'b1;
            for (int i = 0; i < 4; i++) sb[i].push_back(ins4);
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 64) begin
                or4 = 4'($urandom_range(0, 15));
                mid();
                done = ir4;
                cyc++;
                tick();
            end
            if (!done) begin
                chk("rnd_handshake_timeout", 64'(done), 64'd1);
                break;
            end
        end
        iv4 = 1'b0;
        or4 = 4'b0000;
        tick();
        for (int i = 0; i < 4; i++)
            chk($sformatf("rnd_sb_drained_ch%0d", i), 64'(sb[i].size()), 64'd0);
        chk("rnd_tc4_final", 64'(tc4), 64'(NTOK));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
